instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the processor: owns the program counter, fetches instruction words from instruction RAM on request from the control unit, and returns each word with a one-cycle valid pulse. It sits directly upstream of the control unit. Its outputs `ins` and `en_ram_out` feed the control unit's instruction register. It consumes the control unit's `en_ram_in` (fetch request), `en_pc_pulse`, `pc_ctrl` and `offset_addr`.

## Interface
- `ADDR_W`, 8: PC and instruction RAM address width (8..16).
- `DATA_W`, 16: instruction word width.
- `RAM_LAT`, 2: instruction RAM read latency in cycles from `mem_rd` high to `mem_rdata` valid (1..7).
- `RESET_PC`, 0: PC value after reset.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `en_fetch` in 1: fetch request pulse (from control unit `en_ram_in`).
- `en_pc_pulse` in 1: PC update strobe.
- `pc_ctrl` in 2: PC update mode, sampled when `en_pc_pulse`=1.
- `offset_addr` in 8: jump target / branch offset.
- `mem_addr` out ADDR_W: instruction RAM address (registered).
- `mem_rd` out 1: instruction RAM read strobe, one cycle per fetch.
- `mem_rdata` in DATA_W: instruction RAM read data.
- `ins` out DATA_W: fetched instruction, held until the next fetch completes.
- `en_ram_out` out 1: one-cycle pulse, `ins` newly valid.
- `pc` out ADDR_W: current program counter.
- `busy` out 1: fetch in flight.
- `fetch_err` out 1: sticky; set when a request arrives while busy.

## Operation
- Reset values (rst=0 at an edge): `pc`=RESET_PC, `mem_addr`=0, `mem_rd`=0, `ins`=0, `en_ram_out`=0, `busy`=0, `fetch_err`=0, FSM=IDLE, latency counter=0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, `en_fetch`=1: `mem_addr`<=`pc` (value before any same-edge PC update), `mem_rd`<=1, counter<=RAM_LAT, `busy`<=1, go to WAIT.
  - WAIT: `mem_rd`<=0; counter decrements each cycle. When counter=1, `ins`<=`mem_rdata`, `en_ram_out`<=1, go to DONE.
  - DONE: `en_ram_out`<=0, `busy`<=0, go to IDLE. `en_fetch` seen in DONE is treated as while busy.
- `en_fetch`=1 in WAIT/DONE: request ignored, `fetch_err`<=1. The flag stays set until reset.
- PC update happens in any FSM state, on an edge with `en_pc_pulse`=1:
  - 00: hold.
  - 01: `pc`+1.
  - 10: absolute jump, `pc`<=zero-extended `offset_addr`.
  - 11: relative branch, `pc`<=`pc`+sign-extended `offset_addr`.
- Arithmetic is modulo 2^ADDR_W. 0xFF+1 wraps to 0x00 (ADDR_W=8). 0x02+0xFC gives 0xFE.
- A PC update during a fetch in flight does not affect that fetch: its address was latched at request.
- `ins` changes only on fetch completion or reset.

## Timing
- `en_fetch` at edge t gives `mem_rd`=1 and `mem_addr` valid during cycle t+1.
- RAM drives `mem_rdata` valid during cycle t+RAM_LAT.
- The `ins` capture edge is the edge that ends cycle t+RAM_LAT. `en_ram_out`=1 and new `ins` are visible during cycle t+RAM_LAT+1.
- Request-to-valid latency is RAM_LAT+1 cycles. `busy` is high for cycles t+1 through t+RAM_LAT+1.
- The next fetch is accepted at the edge after DONE. Minimum request spacing is RAM_LAT+2 cycles.
- Simultaneous `en_fetch` and `en_pc_pulse` in IDLE: the fetch uses the old `pc`, and `pc` updates on the same edge.
- Reset mid-fetch: the FSM returns to IDLE, no `en_ram_out` pulse is produced, and any late `mem_rdata` is ignored.
- Reset has priority over all other inputs.

## Test plan
- Basic fetch: reset, RAM[0]=0x1234, RAM_LAT=2, `en_fetch` pulse -> `mem_rd`/`mem_addr`=0x00 one cycle later; `ins`=0x1234 with `en_ram_out` pulse 3 cycles after the request; `busy` low afterwards.
- PC modes: `pc`=0x10. Increment -> 0x11; jump with offset 0xA5 -> 0xA5; relative with 0xFC from 0x02 -> 0xFE; increment from 0xFF -> 0x00.
- Overlap: fetch at `pc`=0x05 with a simultaneous increment, then a jump to 0x40 during WAIT -> fetched word is RAM[0x05]; `pc`=0x40 at completion.
- Request while busy: second `en_fetch` during WAIT -> no second `mem_rd`; `fetch_err`=1 and held; the first fetch completes normally.
- Reset mid-fetch: `rst`=0 in the WAIT cycle -> no `en_ram_out`; `ins`=0; `pc`=RESET_PC; a new fetch after release returns RAM[RESET_PC].
- Back-to-back fetches at minimum spacing with RAM_LAT=1 and RAM_LAT=7 -> each returns the correct word; exactly one `en_ram_out` pulse per request.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus: control-unit handshake plus instruction RAM port.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              en_fetch;
  logic              en_pc_pulse;
  logic [1:0]        pc_ctrl;
  logic [7:0]        offset_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] ins;
  logic              en_ram_out;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fetch_err;

  // master: the fetch unit itself
  modport master (
    input  en_fetch, en_pc_pulse, pc_ctrl, offset_addr, mem_rdata,
    output mem_addr, mem_rd, ins, en_ram_out, pc, busy, fetch_err
  );

  // slave: control unit and instruction RAM side
  modport slave (
    output en_fetch, en_pc_pulse, pc_ctrl, offset_addr, mem_rdata,
    input  mem_addr, mem_rd, ins, en_ram_out, pc, busy, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one RAM read per request,
// waits out the fixed RAM latency and returns the word with a valid pulse.
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int RAM_LAT  = 2,
  parameter int RESET_PC = 0
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  localparam logic [2:0]        LAT_LD  = 3'(RAM_LAT);

  state_t              state;
  logic [2:0]          cnt;
  logic [ADDR_W-1:0]   pc_q;
  logic [ADDR_W-1:0]   pc_nxt;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_rd_q;
  logic [DATA_W-1:0]   ins_q;
  logic                en_ram_out_q;
  logic                busy_q;
  logic                err_q;

  assign bus.pc         = pc_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_rd     = mem_rd_q;
  assign bus.ins        = ins_q;
  assign bus.en_ram_out = en_ram_out_q;
  assign bus.busy       = busy_q;
  assign bus.fetch_err  = err_q;

  // Next PC: hold / increment / absolute jump / signed relative branch, all mod 2^ADDR_W
  always_comb begin
    pc_nxt = pc_q;
    if (bus.en_pc_pulse) begin
      unique case (bus.pc_ctrl)
        2'b00: pc_nxt = pc_q;
        2'b01: pc_nxt = pc_q + ADDR_W'(1);
        2'b10: pc_nxt = ADDR_W'(bus.offset_addr);
        2'b11: pc_nxt = pc_q + ADDR_W'($signed(bus.offset_addr));
        default: pc_nxt = pc_q;
      endcase
    end
  end

  // PC register; updates in any FSM state, independent of a fetch in flight
  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RST_PC;
    else      pc_q <= pc_nxt;
  end

  // Fetch FSM: address is latched from the pre-update PC, so a same-edge or
  // later PC change never disturbs the fetch already issued
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      ins_q        <= '0;
      en_ram_out_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // any request outside IDLE (including DONE) is dropped and flagged
      if (bus.en_fetch && state != IDLE) err_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.en_fetch) begin
            mem_addr_q <= pc_q;
            mem_rd_q   <= 1'b1;
            cnt        <= LAT_LD;
            busy_q     <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          mem_rd_q <= 1'b0;
          cnt      <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            ins_q        <= bus.mem_rdata;
            en_ram_out_q <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          en_ram_out_q <= 1'b0;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench: three fetch units (RAM latency 2, 1, 7) share one stimulus stream;
// each has its own latency-accurate RAM and is checked every cycle against a
// timeline model of request/complete times.
module tb_instr_fetch_unit;

  localparam logic [7:0] RST_PC = 8'h03;

  logic       clk;
  logic       rst;
  logic       en_fetch;
  logic       en_pc;
  logic [1:0] pc_ctrl;
  logic [7:0] offset;

  logic [15:0] ram [256];

  logic [2:0][7:0]  o_pc;
  logic [2:0][7:0]  o_maddr;
  logic [2:0]       o_rd;
  logic [2:0]       o_busy;
  logic [2:0]       o_ero;
  logic [2:0][15:0] o_ins;
  logic [2:0]       o_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 7);

    instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    instr_fetch_unit #(.ADDR_W(8), .DATA_W(16), .RAM_LAT(L), .RESET_PC(RST_PC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.en_fetch    = en_fetch;
    assign bus.en_pc_pulse = en_pc;
    assign bus.pc_ctrl     = pc_ctrl;
    assign bus.offset_addr = offset;

    // RAM: data valid only in the cycle RAM_LAT-1 after the read strobe
    logic       dv [1:7];
    logic [7:0] da [1:7];
    logic       v;
    logic [7:0] a;

    always_ff @(posedge clk) begin
      if (!rst) begin
        for (int i = 1; i <= 7; i++) begin
          dv[i] <= 1'b0;
          da[i] <= 8'h00;
        end
      end else begin
        dv[1] <= bus.mem_rd;
        da[1] <= bus.mem_addr;
        for (int i = 2; i <= 7; i++) begin
          dv[i] <= dv[i-1];
          da[i] <= da[i-1];
        end
      end
    end

    if (L == 1) begin : comb_rd
      assign v = bus.mem_rd;
      assign a = bus.mem_addr;
    end else begin : piped_rd
      assign v = dv[L-1];
      assign a = da[L-1];
    end

    assign bus.mem_rdata = v ? ram[a] : {8'hBA, a};

    assign o_pc[g]    = bus.pc;
    assign o_maddr[g] = bus.mem_addr;
    assign o_rd[g]    = bus.mem_rd;
    assign o_busy[g]  = bus.busy;
    assign o_ero[g]   = bus.en_ram_out;
    assign o_ins[g]   = bus.ins;
    assign o_err[g]   = bus.fetch_err;
  end

  // Reference model: PC value plus, per unit, the edge its last fetch was accepted
  logic [7:0]  pc_m;
  int          req_t   [3];
  logic [7:0]  req_a   [3];
  logic [7:0]  maddr_m [3];
  logic [15:0] ins_m   [3];
  logic        err_m   [3];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s lat=%0d cyc=%0d observed=%0h expected=%0h", tag, lat_of(k), cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic p, input logic [1:0] c, input logic [7:0] o);
    rst = r; en_fetch = f; en_pc = p; pc_ctrl = c; offset = o;
    @(posedge clk);
    if (!r) begin
      pc_m = RST_PC;
      for (int k = 0; k < 3; k++) begin
        req_t[k] = -1000; req_a[k] = 8'h00; maddr_m[k] = 8'h00;
        ins_m[k] = 16'h0000; err_m[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int lat;
        lat = lat_of(k);
        if (cyc == req_t[k] + lat) ins_m[k] = ram[req_a[k]];
        if (f) begin
          if (cyc <= req_t[k] + lat + 1) err_m[k] = 1'b1;
          else begin
            req_t[k] = cyc; req_a[k] = pc_m; maddr_m[k] = pc_m;
          end
        end
      end
      if (p) begin
        case (c)
          2'd1: pc_m = 8'(int'(pc_m) + 1);
          2'd2: pc_m = o;
          2'd3: pc_m = 8'(int'(pc_m) + int'($signed(o)));
          default: pc_m = pc_m;
        endcase
      end
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      int lat;
      lat = lat_of(k);
      chk("pc",         k, 32'(o_pc[k]),    32'(pc_m));
      chk("mem_rd",     k, 32'(o_rd[k]),    32'(cyc == req_t[k]));
      chk("mem_addr",   k, 32'(o_maddr[k]), 32'(maddr_m[k]));
      chk("busy",       k, 32'(o_busy[k]),  32'(cyc <= req_t[k] + lat));
      chk("en_ram_out", k, 32'(o_ero[k]),   32'(cyc == req_t[k] + lat));
      chk("ins",        k, 32'(o_ins[k]),   32'(ins_m[k]));
      chk("fetch_err",  k, 32'(o_err[k]),   32'(err_m[k]));
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    ram[0] = 16'h1234;
    rst = 1'b0; en_fetch = 1'b0; en_pc = 1'b0; pc_ctrl = 2'd0; offset = 8'h00;

    // reset state
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 2'd1, 8'h00);
    idle(2);

    // basic fetch from address 0
    step(1'b1, 1'b0, 1'b1, 2'd2, 8'h00);
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    idle(10);

    // PC modes, including wrap and negative branch
    step(1'b1, 1'b0, 1'b1, 2'd2, 8'h10);
    step(1'b1, 1'b0, 1'b1, 2'd1, 8'h00);
    step(1'b1, 1'b0, 1'b1, 2'd2, 8'hA5);
    step(1'b1, 1'b0, 1'b1, 2'd0, 8'h33);
    step(1'b1, 1'b0, 1'b1, 2'd2, 8'h02);
    step(1'b1, 1'b0, 1'b1, 2'd3, 8'hFC);
    step(1'b1, 1'b0, 1'b1, 2'd2, 8'hFF);
    step(1'b1, 1'b0, 1'b1, 2'd1, 8'h00);
    step(1'b1, 1'b0, 1'b1, 2'd3, 8'h7F);

    // fetch with same-edge increment, then jump while in flight
    step(1'b1, 1'b0, 1'b1, 2'd2, 8'h05);
    step(1'b1, 1'b1, 1'b1, 2'd1, 8'h00);
    step(1'b1, 1'b0, 1'b1, 2'd2, 8'h40);
    idle(10);

    // second request while busy
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    idle(1);
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    idle(10);

    // reset in the cycle after the request, then refetch from RESET_PC
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
    idle(10);

    // back-to-back fetches at the minimum spacing for RAM_LAT=1, 7 and 2
    for (int s = 0; s < 3; s++) begin
      int sp;
      sp = (s == 0) ? 3 : ((s == 1) ? 9 : 4);
      step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
      for (int i = 0; i < 6; i++) begin
        step(1'b1, 1'b1, 1'b1, 2'd1, 8'h00);
        idle(sp - 1);
      end
      idle(10);
    end

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 79) != 0), ($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
